result_scoreboard: RTL and testbench

- Synthesizable scoreboard directly downstream of the single-cycle RISC-V processor.
- Consumes the processor's per-instruction Result stream and compares each sample against a loadable table of expected values.
- Counts matches and reports pass/fail plus first-failure diagnostics.
- Lets the instruction-program check run on FPGA or in simulation without a behavioural-delay testbench.

---
 rtl/result_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_result_scoreboard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_scoreboard.sv
// Result-stream scoreboard for the single-cycle RISC-V core.
// Compares retired results against a loadable expected table.
module result_scoreboard #(
   parameter int NUM_CHECKS = 20,
   parameter int IDX_W      = 5,
   parameter int DATA_W     = 32,
   parameter int SKIP       = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] result,
   input  logic              result_valid,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_addr,
   input  logic [DATA_W-1:0] exp_wdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IDX_W:0]    score,
   output logic [IDX_W:0]    index,
   output logic              fail_seen,
   output logic [IDX_W-1:0]  first_fail_idx,
   output logic [DATA_W-1:0] first_fail_data
);

   localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
   localparam logic [IDX_W:0] LP_N    = (IDX_W+1)'(NUM_CHECKS);
   localparam logic [IDX_W:0] LP_LAST = (IDX_W+1)'(NUM_CHECKS - 1);
   localparam logic [SKW-1:0] LP_SKIP = SKW'(SKIP);
   localparam logic [SKW-1:0] LP_ONE  = SKW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SKIP,
      S_RUN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DATA_W-1:0] r_exp [NUM_CHECKS];
   logic [SKW-1:0]    r_skip;
   logic [IDX_W:0]    r_score;
   logic [IDX_W:0]    r_index;
   logic              r_fail_seen;
   logic [IDX_W-1:0]  r_ff_idx;
   logic [DATA_W-1:0] r_ff_data;

   logic              w_idle_done;
   logic              w_start;
   logic              w_we;
   logic              w_skip_step;
   logic              w_skip_end;
   logic              w_cmp;
   logic              w_last;
   logic              w_match;
   logic [IDX_W-1:0]  w_idx;

   assign w_idle_done = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_start     = start && w_idle_done;
   assign w_we        = exp_we && w_idle_done &&
                        ({1'b0, exp_addr} < LP_N);
   assign w_skip_step = (r_state == S_SKIP) && result_valid;
   assign w_skip_end  = (r_skip == LP_ONE);
   assign w_cmp       = (r_state == S_RUN) && result_valid;
   assign w_last      = (r_index == LP_LAST);
   assign w_idx       = r_index[IDX_W-1:0];
   assign w_match     = (result == r_exp[w_idx]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next = (SKIP > 0) ? S_SKIP : S_RUN;
            end
         end
         S_SKIP: begin
            if (result_valid && w_skip_end) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            if (result_valid && w_last) begin
               w_next = S_DONE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      case (r_state)
         S_SKIP, S_RUN: busy = 1'b1;
         S_DONE: begin
            done = 1'b1;
            pass = (r_score == LP_N);
         end
         default: ;
      endcase
   end

   // Table writes are blocked while a run is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            r_exp[i] <= '0;
         end
      end else if (w_we) begin
         r_exp[exp_addr] <= exp_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_skip      <= '0;
         r_score     <= '0;
         r_index     <= '0;
         r_fail_seen <= 1'b0;
         r_ff_idx    <= '0;
         r_ff_data   <= '0;
      end else if (w_start) begin
         r_skip      <= LP_SKIP;
         r_score     <= '0;
         r_index     <= '0;
         r_fail_seen <= 1'b0;
         r_ff_idx    <= '0;
         r_ff_data   <= '0;
      end else if (w_skip_step) begin
         r_skip <= r_skip - LP_ONE;
      end else if (w_cmp) begin
         r_index <= r_index + 1'b1;
         if (w_match) begin
            r_score <= r_score + 1'b1;
         end else if (!r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_ff_idx    <= w_idx;
            r_ff_data   <= result;
         end
      end
   end

   assign score           = r_score;
   assign index           = r_index;
   assign fail_seen       = r_fail_seen;
   assign first_fail_idx  = r_ff_idx;
   assign first_fail_data = r_ff_data;

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard.
// Runs the 20-result program stream through several scenarios.
module tb_result_scoreboard;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] result;
   logic        result_valid;
   logic        exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_wdata;
   logic        busy;
   logic        done;
   logic        pass;
   logic [5:0]  score;
   logic [5:0]  index;
   logic        fail_seen;
   logic [4:0]  first_fail_idx;
   logic [31:0] first_fail_data;

   int n_checks;
   int n_errors;
   int cyc;

   logic [31:0] prog [20] = '{
      32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hb,
      32'h3, 32'hfffffffe, 32'h0, 32'h5, 32'h1, 32'hfffffff4,
      32'h4d2, 32'hfffff8d7, 32'h1, 32'hfffffb2c, 32'h30, 32'h30
   };

   result_scoreboard #(
      .NUM_CHECKS(20),
      .IDX_W(5),
      .DATA_W(32),
      .SKIP(1)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .result(result),
      .result_valid(result_valid),
      .exp_we(exp_we),
      .exp_addr(exp_addr),
      .exp_wdata(exp_wdata),
      .busy(busy),
      .done(done),
      .pass(pass),
      .score(score),
      .index(index),
      .fail_seen(fail_seen),
      .first_fail_idx(first_fail_idx),
      .first_fail_data(first_fail_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"}, 32'(busy), 0);
      check({tag, ".done"}, 32'(done), 0);
      check({tag, ".pass"}, 32'(pass), 0);
      check({tag, ".score"}, 32'(score), 0);
      check({tag, ".index"}, 32'(index), 0);
      check({tag, ".fail"}, 32'(fail_seen), 0);
      check({tag, ".ffidx"}, 32'(first_fail_idx), 0);
      check({tag, ".ffdata"}, first_fail_data, 0);
   endtask

   task automatic load();
      for (int i = 0; i < 20; i++) begin
         exp_we    = 1'b1;
         exp_addr  = 5'(i);
         exp_wdata = prog[i];
         step();
      end
      exp_we = 1'b0;
   endtask

   // Start cycle carries a valid sample that must not be compared.
   task automatic do_start(input string tag);
      start        = 1'b1;
      result_valid = 1'b1;
      result       = 32'hdeadbeef;
      step();
      start        = 1'b0;
      result_valid = 1'b0;
      check({tag, ".st_idx"}, 32'(index), 0);
      check({tag, ".st_score"}, 32'(score), 0);
      check({tag, ".st_busy"}, 32'(busy), 1);
      check({tag, ".st_done"}, 32'(done), 0);
   endtask

   task automatic run(input string tag, input bit gap, input bit bad,
                      input bit zeros, input bit inj, input int stop_at,
                      output int ncyc);
      logic [31:0] d;
      logic [5:0]  held;
      ncyc         = 0;
      result       = 32'h5a5a5a5a;
      result_valid = 1'b1;
      step();
      ncyc++;
      if (gap) begin
         result_valid = 1'b0;
         step();
         ncyc++;
      end
      for (int i = 0; i < 20; i++) begin
         if (i == stop_at) begin
            result_valid = 1'b0;
            return;
         end
         d = zeros ? 32'h0 : prog[i];
         if (bad && i == 9)  d = 32'hfffffffd;
         if (bad && i == 15) d = 32'h0;
         if (i == 19) check({tag, ".early_done"}, 32'(done), 0);
         if (inj && i == 5) begin
            exp_we    = 1'b1;
            exp_addr  = 5'd3;
            exp_wdata = 32'h0badf00d;
            start     = 1'b1;
         end
         result       = d;
         result_valid = 1'b1;
         step();
         ncyc++;
         exp_we = 1'b0;
         start  = 1'b0;
         if (gap && i < 19) begin
            held         = index;
            result_valid = 1'b0;
            result       = 32'hffffffff;
            step();
            ncyc++;
            check({tag, ".gap_idx"}, 32'(index), 32'(held));
         end
      end
      result_valid = 1'b0;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      reset_n      = 1'b0;
      start        = 1'b0;
      result       = '0;
      result_valid = 1'b0;
      exp_we       = 1'b0;
      exp_addr     = '0;
      exp_wdata    = '0;
      #3;
      check_zero("rst");
      step();
      step();
      reset_n = 1'b1;
      step();
      check_zero("idle");

      load();
      do_start("t1");
      run("t1", 0, 0, 0, 0, -1, cyc);
      check("t1.cyc", 32'(cyc), 21);
      check("t1.done", 32'(done), 1);
      check("t1.busy", 32'(busy), 0);
      check("t1.score", 32'(score), 20);
      check("t1.index", 32'(index), 20);
      check("t1.pass", 32'(pass), 1);
      check("t1.fail", 32'(fail_seen), 0);
      result_valid = 1'b1;
      result       = 32'h12345678;
      step();
      step();
      result_valid = 1'b0;
      check("t1.hold_score", 32'(score), 20);
      check("t1.hold_index", 32'(index), 20);
      check("t1.hold_done", 32'(done), 1);

      do_start("t2");
      run("t2", 0, 1, 0, 0, -1, cyc);
      check("t2.done", 32'(done), 1);
      check("t2.score", 32'(score), 18);
      check("t2.pass", 32'(pass), 0);
      check("t2.fail", 32'(fail_seen), 1);
      check("t2.ffidx", 32'(first_fail_idx), 9);
      check("t2.ffdata", first_fail_data, 32'hfffffffd);

      do_start("t3");
      run("t3", 1, 0, 0, 0, -1, cyc);
      check("t3.cyc", 32'(cyc), 41);
      check("t3.done", 32'(done), 1);
      check("t3.score", 32'(score), 20);
      check("t3.pass", 32'(pass), 1);

      do_start("t5");
      run("t5", 0, 0, 0, 1, -1, cyc);
      check("t5.done", 32'(done), 1);
      check("t5.score", 32'(score), 20);
      check("t5.pass", 32'(pass), 1);
      check("t5.index", 32'(index), 20);
      do_start("t5r");
      check("t5r.pass", 32'(pass), 0);

      run("t4", 0, 0, 0, 0, 7, cyc);
      check("t4.index7", 32'(index), 7);
      check("t4.busy", 32'(busy), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("t4");
      step();
      reset_n = 1'b1;
      step();
      check_zero("t4.after");

      exp_we    = 1'b1;
      exp_addr  = 5'd25;
      exp_wdata = 32'h12345678;
      step();
      exp_we = 1'b0;
      do_start("t6z");
      run("t6z", 0, 0, 1, 0, -1, cyc);
      check("t6z.score", 32'(score), 20);
      check("t6z.pass", 32'(pass), 1);

      load();
      do_start("t6");
      run("t6", 0, 0, 0, 0, -1, cyc);
      check("t6.score", 32'(score), 20);
      check("t6.pass", 32'(pass), 1);
      check("t6.fail", 32'(fail_seen), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
